simon_button_decoder: RTL and testbench

SIMON_BUTTON_DECODER -- requirements
Module: simon_button_decoder

---
 rtl/simon_button_decoder.sv | 154 +++++++++++++++
 tb/tb_simon_button_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_button_decoder.sv
// Debounced 4-button decoder for the Simon game: valid after DEBOUNCE_CYCLES+2 edges from first btn sample.
// No backpressure; valid/multi are single-cycle pulses, pressed is a level while the accepted button is held.
module simon_button_decoder #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic       enable,
    output logic [1:0] color,
    output logic       valid,
    output logic       pressed,
    output logic       multi
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    state_t        r_state;
    logic [3:0]    r_held;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_color;
    logic          r_valid;
    logic          r_pressed;
    logic          r_multi;

    logic [3:0]    w_sbtn;
    logic          w_onehot;
    logic          w_multi_hot;
    logic          w_cnt_max;
    logic [CW-1:0] w_cnt_inc;
    state_t        w_state_nxt;
    logic [3:0]    w_held_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_color_nxt;
    logic          w_valid_nxt;
    logic          w_multi_nxt;
    logic          w_pressed_nxt;

    function automatic logic [1:0] enc_color(input logic [3:0] oh);
        logic [1:0] code;
        case (oh)
            4'b0010: code = 2'd1;
            4'b0100: code = 2'd2;
            4'b1000: code = 2'd3;
            default: code = 2'd0;
        endcase
        return code;
    endfunction

    assign w_sbtn      = r_sync2;
    assign w_onehot    = (w_sbtn != 4'd0) && ((w_sbtn & (w_sbtn - 4'd1)) == 4'd0);
    assign w_multi_hot = (w_sbtn != 4'd0) && !w_onehot;
    assign w_cnt_max   = (r_cnt == CNT_MAX);
    // Saturating increment: the counter can never wrap back to zero.
    assign w_cnt_inc   = w_cnt_max ? r_cnt : r_cnt + CW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_held_nxt  = r_held;
        w_cnt_nxt   = r_cnt;
        w_color_nxt = r_color;
        w_valid_nxt = 1'b0;
        w_multi_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (enable && w_onehot) begin
                    w_held_nxt  = w_sbtn;
                    w_state_nxt = S_DEBOUNCE;
                end else if (enable && w_multi_hot) begin
                    w_multi_nxt = 1'b1;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_DEBOUNCE: begin
                if (!enable || (w_sbtn != r_held)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_max) begin
                    w_state_nxt = S_HELD;
                    w_color_nxt = enc_color(r_held);
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            // Extra buttons and enable are ignored until everything is let go.
            S_HELD: begin
                if (w_sbtn == 4'd0) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            S_RELEASE: begin
                if (w_sbtn != 4'd0) begin
                    w_cnt_nxt = '0;
                end else if (w_cnt_max) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_RELEASE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_pressed_nxt = (w_state_nxt == S_HELD);

    // Reset lands in RELEASE so a button held through reset must be let go first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= 4'd0;
            r_sync2   <= 4'd0;
            r_state   <= S_RELEASE;
            r_held    <= 4'd0;
            r_cnt     <= '0;
            r_color   <= 2'd0;
            r_valid   <= 1'b0;
            r_pressed <= 1'b0;
            r_multi   <= 1'b0;
        end else begin
            r_sync1   <= btn;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_held    <= w_held_nxt;
            r_cnt     <= w_cnt_nxt;
            r_color   <= w_color_nxt;
            r_valid   <= w_valid_nxt;
            r_pressed <= w_pressed_nxt;
            r_multi   <= w_multi_nxt;
        end
    end

    assign color   = r_color;
    assign valid   = r_valid;
    assign pressed = r_pressed;
    assign multi   = r_multi;

endmodule

// File: tb/tb_simon_button_decoder.sv
// Directed bench for simon_button_decoder with a scoreboard of expected valid/multi pulses.
module tb_simon_button_decoder;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic       enable;
    logic [1:0] color;
    logic       valid;
    logic       pressed;
    logic       multi;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_multi;
        logic [1:0] col;
        int         at;
    } ev_t;

    ev_t sb[$];

    simon_button_decoder #(.DEBOUNCE_CYCLES(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .enable  (enable),
        .color   (color),
        .valid   (valid),
        .pressed (pressed),
        .multi   (multi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input bit m, input logic [1:0] c, input int at);
        ev_t e;
        e.is_multi = m;
        e.col      = c;
        e.at       = at;
        sb.push_back(e);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Drive a press at a negedge; edge 0 is the next posedge, valid follows edge N+2.
    task automatic press(input logic [3:0] b, input logic [1:0] c);
        btn = b;
        expect_ev(1'b0, c, cyc + N + 3);
    endtask

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (valid || multi) begin
                chk1("valid_multi_exclusive", valid && multi, 1'b0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_pulse observed valid=%b multi=%b expected=none cyc=%0d",
                           valid, multi, cyc);
                end else begin
                    e = sb.pop_front();
                    chk1("pulse_kind_multi", multi, e.is_multi);
                    checks++;
                    assert (cyc === e.at) else begin
                        errors++;
                        $error("FAIL pulse_cycle observed=%0d expected=%0d", cyc, e.at);
                    end
                    if (!e.is_multi) chk2("pulse_color", color, e.col);
                end
            end
        end
    end

    initial begin : stim
        rst_n  = 1'b0;
        enable = 1'b0;
        btn    = 4'd0;
        tick(3);
        chk2("reset_color", color, 2'd0);
        chk1("reset_valid", valid, 1'b0);
        chk1("reset_pressed", pressed, 1'b0);
        chk1("reset_multi", multi, 1'b0);

        // Button held through reset must not be accepted.
        btn    = 4'b0001;
        enable = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(12);
        chk1("held_through_reset_pressed", pressed, 1'b0);
        btn = 4'd0;
        tick(10);

        // Clean Blue press and release timing of pressed.
        press(4'b0100, 2'd2);
        tick(8);
        chk1("blue_pressed", pressed, 1'b1);
        chk2("blue_color_hold", color, 2'd2);
        tick(5);
        btn = 4'd0;
        tick(2);
        chk1("blue_pressed_before_release", pressed, 1'b1);
        tick(1);
        chk1("blue_pressed_after_release", pressed, 1'b0);
        chk2("color_holds_after_release", color, 2'd2);
        tick(10);

        // Red toggling every 2 cycles, then stable.
        for (int i = 0; i < 5; i++) begin
            btn = 4'b0001;
            tick(2);
            btn = 4'd0;
            tick(2);
        end
        press(4'b0001, 2'd0);
        tick(8);
        chk1("red_pressed", pressed, 1'b1);
        btn = 4'd0;
        tick(10);

        // Two buttons at press start -> multi, then Yellow.
        btn = 4'b1010;
        expect_ev(1'b1, 2'd0, cyc + 3);
        tick(4);
        chk1("multi_no_pressed", pressed, 1'b0);
        btn = 4'd0;
        tick(6);
        press(4'b1000, 2'd3);
        tick(8);
        chk1("yellow_pressed", pressed, 1'b1);
        btn = 4'd0;
        tick(10);

        // Green with release bounce; 3 zeros is too short, 4 zeros reaches IDLE.
        press(4'b0010, 2'd1);
        tick(8);
        btn = 4'd0;    tick(1);
        btn = 4'b0010; tick(1);
        btn = 4'd0;    tick(2);
        btn = 4'b0010; tick(1);
        btn = 4'd0;    tick(3);
        btn = 4'b0010; tick(8);
        chk1("bounce_no_pressed", pressed, 1'b0);
        btn = 4'd0;
        tick(4);
        press(4'b0010, 2'd1);
        tick(8);
        chk1("green_after_release_pressed", pressed, 1'b1);
        btn = 4'd0;
        tick(10);

        // Disabled input is ignored.
        enable = 1'b0;
        btn    = 4'b0010;
        tick(20);
        btn = 4'd0;
        tick(4);
        enable = 1'b1;

        // Enable dropped mid-DEBOUNCE.
        btn = 4'b0010;
        tick(4);
        enable = 1'b0;
        tick(3);
        btn = 4'd0;
        tick(4);
        enable = 1'b1;
        tick(2);

        // Reset while HELD with the button still down.
        press(4'b0100, 2'd2);
        tick(8);
        chk1("pre_reset_pressed", pressed, 1'b1);
        rst_n = 1'b0;
        tick(1);
        chk1("reset_held_pressed", pressed, 1'b0);
        chk1("reset_held_valid", valid, 1'b0);
        chk2("reset_held_color", color, 2'd0);
        rst_n = 1'b1;
        tick(12);
        chk1("post_reset_still_held", pressed, 1'b0);
        btn = 4'd0;
        tick(4);
        press(4'b0100, 2'd2);
        tick(8);
        chk1("post_reset_press_pressed", pressed, 1'b1);
        btn = 4'd0;
        tick(10);

        // Reset mid-DEBOUNCE aborts without valid.
        btn = 4'b0001;
        tick(4);
        rst_n = 1'b0;
        btn   = 4'd0;
        tick(1);
        chk1("reset_debounce_valid", valid, 1'b0);
        chk1("reset_debounce_pressed", pressed, 1'b0);
        rst_n = 1'b1;
        tick(10);
        press(4'b1000, 2'd3);
        tick(8);
        chk2("final_color", color, 2'd3);
        btn = 4'd0;
        tick(10);

        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL scoreboard_drained observed=%0d pending expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
